mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Multicycle main control unit for the MIPS core; the sequential successor to the single-cycle main decoder. Sequences each instruction over multiple states and drives the shared-memory / single-ALU datapath. Supports R-type, LW, SW, BEQ, ADDI and J, plus the optional JM (memory-indirect jump) and BGE extensions. Includes a memory ready handshake, a retire pulse and configurable illegal-opcode handling.

## Interface
- EXT_OPS, default 1: 1 = JM (6'b110010) and BGE (6'b110011) decoded; 0 = both treated as illegal.
- MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- TRAP_ON_ILLEGAL, default 1: 1 = illegal op enters HALT; 0 = illegal op returns to FETCH (NOP).
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode field of the instruction register (valid from DECODE on).
- mem_ready  in  1  memory completed the current access this cycle.
- pcwrite, irwrite, memwrite, regwrite  out  1  write enables.
- iord, alusrca, regdst, memtoreg, branch, bge  out  1  datapath selects/flags.
- alusrcb  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target, 11 memory data register.
- aluop  out  2  00 add, 01 sub, 10 funct-decoded.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  sticky; set on an illegal op, cleared only by reset.
- state  out  5  current state code (debug).

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, BGE 12, JMADR 13, JMRD 14, JMPC 15, HALT 16.
- Any output not listed for a state is 0.
- FETCH: alusrcb=01; irwrite=pcwrite=rdy. Go to DECODE when rdy, else stay.
- DECODE: alusrcb=11. Next state by op:
  - 000000 → EXECUTE
  - 100011/101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 110010 → JMADR, 110011 → BGE (EXT_OPS=1 only)
  - anything else: illegal.
- MEMADR: alusrca=1, alusrcb=10. LW → MEMRD; SW → MEMWR.
- MEMRD: iord=1. Go to MEMWB on rdy.
- MEMWB: memtoreg=1, regwrite=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1 (held until rdy). Go to FETCH on rdy.
- EXECUTE: alusrca=1, aluop=10. Go to ALUWB.
- ALUWB: regdst=1, regwrite=1. Go to FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. Go to FETCH.
- BGE: alusrca=1, aluop=01, pcsrc=01, bge=1. Go to FETCH. The datapath forms pcen = pcwrite | (branch & zero) | (bge & ~aluresult[31]).
- ADDIEX: alusrca=1, alusrcb=10. Go to ADDIWB.
- ADDIWB: regwrite=1. Go to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- JMADR: alusrca=1, alusrcb=10. Go to JMRD.
- JMRD: iord=1. Go to JMPC on rdy.
- JMPC: pcsrc=11, pcwrite=1. Go to FETCH.
- HALT: all outputs 0 except illegal=1. Stays in HALT until reset.
- Illegal op in DECODE: illegal is set on the next edge. Go to HALT if TRAP_ON_ILLEGAL=1, else to FETCH.
- instr_done=1 in: MEMWB, ALUWB, BRANCH, BGE, ADDIWB, JUMP, JMPC, and MEMWR when rdy. Never in HALT.
- rdy = mem_ready if MEM_HANDSHAKE=1, else 1.

## Timing
- Reset (async, reset_n=0): state=FETCH, illegal=0. pcwrite, irwrite, memwrite, regwrite and instr_done are forced 0 while reset_n=0; the other outputs take their FETCH values (alusrcb=01, rest 0).
- Release: first fetch occurs on the first edge with reset_n=1 and rdy=1.
- pcwrite/irwrite in FETCH and instr_done in MEMWR are combinational in rdy (Mealy). All other outputs depend on state only.
- Cycles with rdy always 1: R/ADDI 4, LW 5, SW 4, BEQ/BGE/J 3, JM 5. Each memory state adds one cycle per rdy=0 cycle.
- Reset asserted mid-instruction aborts it immediately; no write enable is asserted after reset_n falls.

## Test plan
- Reset: reset_n=0 mid-MEMWR → state=0 and memwrite=0 with no clock edge. Release with mem_ready=1 → DECODE next cycle.
- ADDI, rdy=1: states 0,1,9,10; regwrite=1 and instr_done=1 only in state 10; total 4 cycles.
- LW with mem_ready low for 2 cycles in MEMRD: state stays 3 for 3 cycles; iord=1 throughout; then 4 with memtoreg=1, regwrite=1.
- JM, EXT_OPS=1: states 0,1,13,14,15; pcsrc=11 and pcwrite=1 in 15. Same op with EXT_OPS=0 and TRAP_ON_ILLEGAL=1 → state 16, illegal=1, all enables 0 forever.
- BGE: bge=1, aluop=01, pcsrc=01 and pcwrite=0 in state 12; instr_done pulses once.
- Op 6'b111111 with TRAP_ON_ILLEGAL=0: DECODE → FETCH; illegal=1 stays set; the next valid instruction executes normally.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback states, with a memory-ready handshake and illegal-opcode handling.
module mc_ctrl_fsm #(
  parameter bit EXT_OPS         = 1'b1,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       branch,
  output logic       bge,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD  = 5'd3,
    S_MEMWB   = 5'd4,  S_MEMWR  = 5'd5,  S_EXECUTE = 5'd6, S_ALUWB  = 5'd7,
    S_BRANCH  = 5'd8,  S_ADDIEX = 5'd9,  S_ADDIWB = 5'd10, S_JUMP   = 5'd11,
    S_BGE     = 5'd12, S_JMADR  = 5'd13, S_JMRD   = 5'd14, S_JMPC   = 5'd15,
    S_HALT    = 5'd16
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic       branch;
    logic       bge;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       done;   // retire pulse for states that always finish in one cycle
    logic       fetch;  // FETCH: pcwrite/irwrite follow rdy
    logic       memwr;  // MEMWR: retire follows rdy
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JM    = 6'b110010;
  localparam logic [5:0] OP_BGE   = 6'b110011;

  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alusrcb = 2'b01; c.fetch = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.memwr = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                       c.branch = 1'b1; c.done = 1'b1; end
      S_BGE:     begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                       c.bge = 1'b1; c.done = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  begin c.regwrite = 1'b1; c.done = 1'b1; end
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
      S_JMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_JMRD:    c.iord = 1'b1;
      S_JMPC:    begin c.pcsrc = 2'b11; c.pcwrite = 1'b1; c.done = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctl_t   r_ctl;
  logic   r_illegal;
  state_t w_next_state;
  logic   w_illegal_op;
  logic   w_rdy;

  assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH:  if (w_rdy) w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          OP_JM:        if (EXT_OPS) w_next_state = S_JMADR; else w_illegal_op = 1'b1;
          OP_BGE:       if (EXT_OPS) w_next_state = S_BGE;   else w_illegal_op = 1'b1;
          default:      w_illegal_op = 1'b1;
        endcase
        if (w_illegal_op) w_next_state = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR:  w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (w_rdy) w_next_state = S_MEMWB;
      S_MEMWR:   if (w_rdy) w_next_state = S_FETCH;
      S_JMRD:    if (w_rdy) w_next_state = S_JMPC;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_JMADR:   w_next_state = S_JMRD;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_ctl     <= ctl_for(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ctl   <= ctl_for(w_next_state);
      if (w_illegal_op) r_illegal <= 1'b1;
    end
  end

  // Mealy terms are gated by reset_n so nothing writes while reset is held, even with mem_ready high.
  assign pcwrite    = reset_n & (r_ctl.pcwrite | (r_ctl.fetch & w_rdy));
  assign irwrite    = reset_n & r_ctl.fetch & w_rdy;
  assign memwrite   = reset_n & r_ctl.memwrite;
  assign regwrite   = reset_n & r_ctl.regwrite;
  assign instr_done = reset_n & (r_ctl.done | (r_ctl.memwr & w_rdy));
  assign iord       = r_ctl.iord;
  assign alusrca    = r_ctl.alusrca;
  assign regdst     = r_ctl.regdst;
  assign memtoreg   = r_ctl.memtoreg;
  assign branch     = r_ctl.branch;
  assign bge        = r_ctl.bge;
  assign alusrcb    = r_ctl.alusrcb;
  assign pcsrc      = r_ctl.pcsrc;
  assign aluop      = r_ctl.aluop;
  assign illegal    = r_illegal;
  assign state      = r_state;

endmodule
